// File: rtl/symbol_iterator_if.sv
// Edit, iteration and display signals of the formula buffer.
interface symbol_iterator_if #(
   parameter int unsigned SYMBOL_WIDTH = 7,
   parameter int unsigned LEN_WIDTH    = 7
);
   logic [SYMBOL_WIDTH-1:0] edit_symbol;
   logic                    edit_append;
   logic                    edit_backspace;
   logic                    edit_clear;
   logic                    full;
   logic [LEN_WIDTH-1:0]    length;
   logic                    iter_restart;
   logic                    iterating;
   logic                    symbol_iter_en;
   logic [SYMBOL_WIDTH-1:0] symbol;
   logic                    symbol_valid;
   logic [LEN_WIDTH-1:0]    display_addr;
   logic [SYMBOL_WIDTH-1:0] display_symbol;

   modport master (
      output edit_symbol, edit_append, edit_backspace, edit_clear,
      output iter_restart, symbol_iter_en, display_addr,
      input  full, length, iterating, symbol, symbol_valid, display_symbol
   );

   modport slave (
      input  edit_symbol, edit_append, edit_backspace, edit_clear,
      input  iter_restart, symbol_iter_en, display_addr,
      output full, length, iterating, symbol, symbol_valid, display_symbol
   );
endinterface

// File: rtl/symbol_iterator.sv
// Formula text buffer: editable while idle, streamed one symbol per request
// while iterating, with a zero symbol marking the end of the formula.
module symbol_iterator #(
   parameter int unsigned SYMBOL_WIDTH = 7,
   parameter int unsigned CAPACITY     = 64,
   parameter int unsigned LEN_WIDTH    = $clog2(CAPACITY + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   symbol_iterator_if.slave    bus
);
   localparam int unsigned ADDR_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
   localparam logic [LEN_WIDTH-1:0] CAP_LEN = LEN_WIDTH'(CAPACITY);

   typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    length_q, length_d;
   logic [LEN_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic                    full_q, full_d;
   logic                    iterating_q;
   logic                    term_q, term_d;
   logic                    valid_q, valid_d;
   logic                    wr_en;
   logic                    in_range;
   logic [SYMBOL_WIDTH-1:0] symbol_q;
   logic [SYMBOL_WIDTH-1:0] display_q;

   logic [SYMBOL_WIDTH-1:0] mem [CAPACITY];

   // Next-state, edit and request decode; term_q holds off requests for the
   // one cycle in which the terminator is on the output before leaving ITER.
   always_comb begin
      state_d  = state_q;
      length_d = length_q;
      rd_ptr_d = rd_ptr_q;
      term_d   = 1'b0;
      valid_d  = 1'b0;
      wr_en    = 1'b0;
      in_range = (rd_ptr_q < length_q);
      unique case (state_q)
         IDLE: begin
            if (bus.edit_clear) begin
               length_d = '0;
            end else if (bus.edit_backspace) begin
               if (length_q != '0) length_d = length_q - LEN_WIDTH'(1);
            end else if (bus.edit_append) begin
               if ((length_q < CAP_LEN) && (bus.edit_symbol != '0)) begin
                  wr_en    = 1'b1;
                  length_d = length_q + LEN_WIDTH'(1);
               end
            end
            if (bus.iter_restart) begin
               state_d  = ITER;
               rd_ptr_d = '0;
            end
         end
         ITER: begin
            if (bus.iter_restart) begin
               rd_ptr_d = '0;
            end else if (term_q) begin
               state_d = IDLE;
            end else if (bus.symbol_iter_en) begin
               valid_d = 1'b1;
               if (in_range) rd_ptr_d = rd_ptr_q + LEN_WIDTH'(1);
               else          term_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      full_d = (length_d == CAP_LEN);
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         length_q    <= '0;
         rd_ptr_q    <= '0;
         full_q      <= 1'b0;
         iterating_q <= 1'b0;
         term_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         length_q    <= length_d;
         rd_ptr_q    <= rd_ptr_d;
         full_q      <= full_d;
         iterating_q <= (state_d == ITER);
         term_q      <= term_d;
         valid_q     <= valid_d;
      end
   end

   // Registered read ports: iteration symbol (held between strobes) and display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         symbol_q  <= '0;
         display_q <= '0;
      end else begin
         if (valid_d) symbol_q <= in_range ? mem[ADDR_W'(rd_ptr_q)] : '0;
         display_q <= (bus.display_addr < length_q) ? mem[ADDR_W'(bus.display_addr)] : '0;
      end
   end

   // Buffer write port; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[ADDR_W'(length_q)] <= bus.edit_symbol;
   end

   assign bus.full           = full_q;
   assign bus.length         = length_q;
   assign bus.iterating      = iterating_q;
   assign bus.symbol         = symbol_q;
   assign bus.symbol_valid   = valid_q;
   assign bus.display_symbol = display_q;
endmodule

// File: tb/tb_symbol_iterator.sv
// Directed bench for symbol_iterator with a buffer model and symbol scoreboard.
module tb_symbol_iterator;
   localparam int unsigned SW  = 7;
   localparam int unsigned CAP = 64;
   localparam int unsigned LW  = $clog2(CAP + 1);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   symbol_iterator_if #(.SYMBOL_WIDTH(SW), .LEN_WIDTH(LW)) bus ();

   symbol_iterator #(.SYMBOL_WIDTH(SW), .CAPACITY(CAP), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            checks = 0;
   int            errors = 0;
   logic [SW-1:0] sb[$];
   logic [SW-1:0] model_buf[$];
   bit            model_iter;
   int            model_pos;
   logic [SW-1:0] last_sym;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle edit / restart; the model applies edits only when idle.
   task automatic edit(input bit c, input bit b, input bit a, input bit rs, input bit en,
                       input logic [SW-1:0] s);
      bus.edit_clear     = c;
      bus.edit_backspace = b;
      bus.edit_append    = a;
      bus.edit_symbol    = s;
      bus.iter_restart   = rs;
      bus.symbol_iter_en = en;
      tick();
      bus.edit_clear     = 1'b0;
      bus.edit_backspace = 1'b0;
      bus.edit_append    = 1'b0;
      bus.edit_symbol    = '0;
      bus.iter_restart   = 1'b0;
      bus.symbol_iter_en = 1'b0;
      if (!model_iter) begin
         if (c) model_buf.delete();
         else if (b) begin
            if (model_buf.size() > 0) void'(model_buf.pop_back());
         end else if (a) begin
            if (model_buf.size() < int'(CAP) && s != '0) model_buf.push_back(s);
         end
      end
      if (rs) begin
         model_iter = 1'b1;
         model_pos  = 0;
      end
      check("length", 32'(bus.length), 32'(model_buf.size()));
      check("full", 32'(bus.full), 32'(model_buf.size() == int'(CAP)));
      check("iterating", 32'(bus.iterating), 32'(model_iter));
      check("no_valid_on_edit", 32'(bus.symbol_valid), 32'(0));
   endtask

   // Single-cycle request, then one strobe-low cycle, then gap idle cycles.
   task automatic request(input int gap);
      logic [SW-1:0] e;
      bit            term;
      term = 1'b0;
      bus.symbol_iter_en = 1'b1;
      if (model_iter) begin
         if (model_pos < model_buf.size()) begin
            sb.push_back(model_buf[model_pos]);
            model_pos++;
         end else begin
            sb.push_back('0);
            term = 1'b1;
         end
      end
      tick();
      bus.symbol_iter_en = 1'b0;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("valid", 32'(bus.symbol_valid), 32'(1));
         check("symbol", 32'(bus.symbol), 32'(e));
         check("iter_in_delivery", 32'(bus.iterating), 32'(1));
         last_sym = e;
         if (term) model_iter = 1'b0;
      end else begin
         check("idle_valid", 32'(bus.symbol_valid), 32'(0));
         check("symbol_hold_idle", 32'(bus.symbol), 32'(last_sym));
      end
      tick();
      check("strobe_one_cycle", 32'(bus.symbol_valid), 32'(0));
      check("symbol_hold", 32'(bus.symbol), 32'(last_sym));
      check("iterating_after", 32'(bus.iterating), 32'(model_iter));
      repeat (gap) tick();
   endtask

   task automatic display(input logic [LW-1:0] addr, input logic [SW-1:0] exp);
      bus.display_addr = addr;
      tick();
      check("display", 32'(bus.display_symbol), 32'(exp));
   endtask

   task automatic check_reset_outputs();
      check("rst_length", 32'(bus.length), 32'(0));
      check("rst_full", 32'(bus.full), 32'(0));
      check("rst_iterating", 32'(bus.iterating), 32'(0));
      check("rst_valid", 32'(bus.symbol_valid), 32'(0));
      check("rst_symbol", 32'(bus.symbol), 32'(0));
      check("rst_display", 32'(bus.display_symbol), 32'(0));
   endtask

   task automatic model_reset();
      model_buf.delete();
      sb.delete();
      model_iter = 1'b0;
      model_pos  = 0;
      last_sym   = '0;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.edit_symbol    = '0;
      bus.edit_append    = 1'b0;
      bus.edit_backspace = 1'b0;
      bus.edit_clear     = 1'b0;
      bus.iter_restart   = 1'b0;
      bus.symbol_iter_en = 1'b0;
      bus.display_addr   = '0;
      model_reset();
      repeat (2) tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick();

      // "5 -1" streamed with requests 11 cycles apart.
      edit(0, 0, 1, 0, 0, 7'h35);
      edit(0, 0, 1, 0, 0, 7'h20);
      edit(0, 0, 1, 0, 0, 7'h2D);
      edit(0, 0, 1, 0, 0, 7'h31);
      display(LW'(2), 7'h2D);
      display(LW'(4), 7'h00);
      edit(0, 0, 0, 1, 0, '0);
      for (int i = 0; i < 5; i++) request(9);
      check("idle_after_term", 32'(bus.iterating), 32'(0));
      request(0);

      // Empty buffer iterates straight to the terminator.
      edit(1, 0, 0, 0, 0, '0);
      edit(0, 0, 0, 1, 0, '0);
      request(0);

      // Fill to capacity, overflow append, display boundary.
      for (int i = 0; i < int'(CAP); i++) edit(0, 0, 1, 0, 0, 7'h61);
      check("full_len", 32'(bus.length), 32'(64));
      edit(0, 0, 1, 0, 0, 7'h62);
      display(LW'(63), 7'h61);
      display(LW'(64), 7'h00);
      edit(0, 1, 0, 0, 0, '0);

      // Edit corner cases and priority.
      edit(1, 0, 0, 0, 0, '0);
      edit(0, 1, 0, 0, 0, '0);
      edit(1, 0, 1, 0, 0, 7'h78);
      edit(0, 0, 1, 0, 0, 7'h00);
      edit(0, 0, 1, 0, 0, 7'h71);
      edit(0, 1, 1, 0, 0, 7'h72);
      edit(1, 1, 1, 0, 0, 7'h73);

      // Edits during ITER are ignored; iteration unaffected.
      edit(0, 0, 1, 0, 0, 7'h61);
      edit(0, 0, 1, 0, 0, 7'h62);
      edit(0, 0, 0, 1, 0, '0);
      edit(0, 0, 1, 0, 0, 7'h7A);
      request(0);
      request(0);
      request(0);

      // Restart mid-iteration, with a same-cycle request that must be dropped.
      edit(0, 0, 0, 1, 0, '0);
      request(0);
      edit(0, 0, 0, 1, 1, '0);
      request(0);
      request(0);
      request(0);

      // Append and restart together: new length visible to the iteration.
      edit(0, 0, 1, 1, 0, 7'h63);
      for (int i = 0; i < 4; i++) request(0);

      // Reset in the middle of an iteration.
      edit(1, 0, 0, 0, 0, '0);
      edit(0, 0, 1, 0, 0, 7'h77);
      edit(0, 0, 1, 0, 0, 7'h78);
      edit(0, 0, 1, 0, 0, 7'h79);
      edit(0, 0, 1, 0, 0, 7'h7A);
      edit(0, 0, 0, 1, 0, '0);
      request(0);
      request(0);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) request(0);
      check("len_after_reset", 32'(bus.length), 32'(0));

      check("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/symbol_iterator.md
SYMBOL_ITERATOR -- requirements
Module: symbol_iterator

Interface
REQ-001 The module SHALL have parameter SYMBOL_WIDTH, default 7: width of one ASCII symbol.
REQ-002 The module SHALL have parameter CAPACITY, default 64: maximum stored formula length in symbols.
REQ-003 The module SHALL have parameter LEN_WIDTH, default $clog2(CAPACITY+1): width of length/pointer values.
REQ-004 The module SHALL use a single clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 edit_symbol  input  SYMBOL_WIDTH  symbol to append.
REQ-008 edit_append  input  1  append edit_symbol at end of buffer.
REQ-009 edit_backspace  input  1  remove last symbol.
REQ-010 edit_clear  input  1  empty the buffer.
REQ-011 full  output  1  high when length == CAPACITY.
REQ-012 length  output  LEN_WIDTH  current number of stored symbols.
REQ-013 iter_restart  input  1  start a new iteration from symbol 0.
REQ-014 iterating  output  1  high while in state ITER.
REQ-015 symbol_iter_en  input  1  consumer request for the next symbol.
REQ-016 symbol  output  SYMBOL_WIDTH  delivered symbol; 0 marks end of formula.
REQ-017 symbol_valid  output  1  one-cycle strobe qualifying symbol.
REQ-018 display_addr  input  LEN_WIDTH  read address for the on-screen text renderer.
REQ-019 display_symbol  output  SYMBOL_WIDTH  buffer content at display_addr, one-cycle latency; 0 when display_addr >= length.

Function
REQ-020 The module SHALL have two states: IDLE and ITER.
REQ-021 IDLE -> ITER on iter_restart; rd_ptr SHALL be set to 0.
REQ-022 In ITER, symbol_iter_en high in cycle N SHALL produce symbol_valid high in cycle N+1 only, with symbol = mem[rd_ptr] if rd_ptr < length, else 0.
REQ-023 rd_ptr SHALL increment on each accepted request while rd_ptr < length.
REQ-024 The cycle that delivers the terminator 0 SHALL be followed by a return to IDLE.
REQ-025 symbol_iter_en in IDLE SHALL be ignored; symbol_valid stays 0.
REQ-026 iter_restart while in ITER SHALL reset rd_ptr to 0 and remain in ITER; a same-cycle symbol_iter_en SHALL be ignored.
REQ-027 symbol SHALL hold its last value when symbol_valid is 0.
REQ-028 Edits (append/backspace/clear) SHALL apply only in IDLE; in ITER they SHALL be ignored.
REQ-029 Edit priority when asserted together: clear > backspace > append.
REQ-030 Append SHALL write mem[length] and increment length; ignored when full or edit_symbol == 0.
REQ-031 Backspace SHALL decrement length; ignored when length == 0.
REQ-032 Clear SHALL set length to 0; memory contents need not be erased.
REQ-033 Edit and iter_restart in the same IDLE cycle: edit applies, then ITER is entered with updated length visible from the first request.
REQ-034 Buffer memory SHALL be synchronous-read RAM inferable as distributed or block RAM; only control registers are reset.

Reset
REQ-035 On rst_n low: state IDLE, length 0, rd_ptr 0, symbol_valid 0, symbol 0, iterating 0, full 0, display_symbol 0.
REQ-036 Reset asserted mid-iteration SHALL abort immediately; no further symbol_valid until a new iter_restart after reset release.

Verification
REQ-037 Append "5"," ","-","1"; pulse iter_restart; five single-cycle requests 110 ns apart -> symbols 0x35,0x20,0x2D,0x31,0x00 each with one-cycle valid; iterating falls after the 0.
REQ-038 Append 64 symbols 'a' -> full=1, length=64; 65th append -> length stays 64; display_addr=63 -> display_symbol 0x61 next cycle.
REQ-039 Backspace at length 0 -> length 0; append 'x' with edit_clear same cycle -> length 0.
REQ-040 During ITER assert edit_append 'z' -> length unchanged; iteration continues normally.
REQ-041 Reset pulled low after 2 of 4 symbols delivered -> all outputs at reset values; requests after release with no restart -> no symbol_valid.
REQ-042 Iterate empty buffer: restart, one request -> symbol 0 with valid, return to IDLE.
